// File: rtl/dsp_result_collector.sv
// Result collector for a CEIN-gated DSP slice: a token shift register tracks issued operands,
// and results are buffered in a first-word-fall-through FIFO with credit-based flow control.
module dsp_result_collector #(
    parameter int WIDTH   = 48,
    parameter int LATENCY = 3,
    parameter int DEPTH   = 4
) (
    input  logic                     CLK,
    input  logic                     RSTIN,
    input  logic                     CEIN,
    input  logic                     IN_VALID,
    input  logic [WIDTH-1:0]         P_IN,
    input  logic                     CARRY_IN,
    output logic [WIDTH-1:0]         OUT,
    output logic                     OUT_CARRY,
    output logic                     OUT_VALID,
    input  logic                     OUT_READY,
    output logic                     CREDIT_OK,
    output logic [$clog2(DEPTH):0]   COUNT,
    output logic                     OVERFLOW
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam int TW = (LATENCY > 0) ? LATENCY : 1;

    logic [TW-1:0]    tok;
    logic             push;
    logic             pop;
    logic             full;
    logic             empty;
    logic             accept;
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [CW-1:0]    count;
    logic             overflow;
    logic [WIDTH:0]   mem [DEPTH];
    logic [WIDTH:0]   head;

    function automatic int popcount(input logic [TW-1:0] v);
        int n;
        n = 0;
        for (int i = 0; i < TW; i++) begin
            n += int'(v[i]);
        end
        return n;
    endfunction

    // Token stage: one bit per operand in flight, advancing on the same CEIN edges as the slice.
    generate
        if (LATENCY == 0) begin : g_no_tok
            assign tok  = '0;
            assign push = CEIN & IN_VALID;
        end else begin : g_tok
            always_ff @(posedge CLK) begin
                if (RSTIN) begin
                    tok <= '0;
                end else if (CEIN) begin
                    tok <= (tok << 1) | TW'(IN_VALID);
                end
            end
            assign push = CEIN & tok[TW-1];
        end
    endgenerate

    assign empty  = (count == '0);
    assign full   = (count == CW'(DEPTH));
    assign pop    = ~empty & OUT_READY;
    // A full FIFO still accepts when the head leaves on the same edge.
    assign accept = push & (~full | pop);

    // FIFO stage: storage carries no reset, only the pointers and flags do.
    always_ff @(posedge CLK) begin
        if (accept) begin
            mem[wr_ptr] <= {CARRY_IN, P_IN};
        end
    end

    always_ff @(posedge CLK) begin
        if (RSTIN) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            overflow <= 1'b0;
        end else begin
            if (accept) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({accept, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
            if (push & ~accept) begin
                overflow <= 1'b1;
            end
        end
    end

    // Output stage: head shown combinationally, forced to zero while empty.
    assign head      = mem[rd_ptr];
    assign OUT       = empty ? '0 : head[WIDTH-1:0];
    assign OUT_CARRY = empty ? 1'b0 : head[WIDTH];
    assign OUT_VALID = ~empty;
    assign COUNT     = count;
    assign OVERFLOW  = overflow;
    assign CREDIT_OK = (int'(count) + popcount(tok)) < DEPTH;

endmodule

// File: tb/tb_dsp_result_collector.sv
// Directed bench for dsp_result_collector (LATENCY=3, DEPTH=4): latency, CE stall,
// credit, overflow, full push+pop, drain order and reset.
module tb_dsp_result_collector;

    localparam int WIDTH = 48;

    logic             CLK = 1'b0;
    logic             RSTIN;
    logic             CEIN;
    logic             IN_VALID;
    logic [WIDTH-1:0] P_IN;
    logic             CARRY_IN;
    logic [WIDTH-1:0] OUT;
    logic             OUT_CARRY;
    logic             OUT_VALID;
    logic             OUT_READY;
    logic             CREDIT_OK;
    logic [2:0]       COUNT;
    logic             OVERFLOW;

    int vectors = 0;
    int miscompares = 0;

    dsp_result_collector #(.WIDTH(WIDTH), .LATENCY(3), .DEPTH(4)) dut (
        .CLK(CLK), .RSTIN(RSTIN), .CEIN(CEIN), .IN_VALID(IN_VALID),
        .P_IN(P_IN), .CARRY_IN(CARRY_IN), .OUT(OUT), .OUT_CARRY(OUT_CARRY),
        .OUT_VALID(OUT_VALID), .OUT_READY(OUT_READY), .CREDIT_OK(CREDIT_OK),
        .COUNT(COUNT), .OVERFLOW(OVERFLOW)
    );

    always #5 CLK = ~CLK;

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    initial begin
        RSTIN = 1'b1; CEIN = 1'b0; IN_VALID = 1'b0; P_IN = '0; CARRY_IN = 1'b0; OUT_READY = 1'b0;
        step(); step();
        RSTIN = 1'b0;
        check("rst_count", 64'(COUNT), 64'd0);
        check("rst_valid", 64'(OUT_VALID), 64'd0);
        check("rst_out", 64'(OUT), 64'd0);
        check("rst_ovf", 64'(OVERFLOW), 64'd0);
        check("rst_credit", 64'(CREDIT_OK), 64'd1);

        // Latency: push on the third edge after the issue edge
        CEIN = 1'b1; IN_VALID = 1'b1;
        step();
        IN_VALID = 1'b0;
        check("lat_e0_valid", 64'(OUT_VALID), 64'd0);
        step();
        check("lat_e1_valid", 64'(OUT_VALID), 64'd0);
        step();
        check("lat_e2_valid", 64'(OUT_VALID), 64'd0);
        P_IN = 48'h5;
        step();
        P_IN = '0;
        check("lat_valid", 64'(OUT_VALID), 64'd1);
        check("lat_out", 64'(OUT), 64'h5);
        check("lat_count", 64'(COUNT), 64'd1);
        OUT_READY = 1'b1;
        step();
        OUT_READY = 1'b0;
        check("lat_pop_valid", 64'(OUT_VALID), 64'd0);

        // CE stall mid-flight; IN_VALID during stall is ignored
        IN_VALID = 1'b1;
        step();
        IN_VALID = 1'b0;
        step();
        CEIN = 1'b0; IN_VALID = 1'b1; P_IN = 48'h7;
        step(); step(); step(); step();
        check("stall_valid", 64'(OUT_VALID), 64'd0);
        check("stall_count", 64'(COUNT), 64'd0);
        CEIN = 1'b1; IN_VALID = 1'b0; P_IN = '0;
        step();
        check("stall_e1_valid", 64'(OUT_VALID), 64'd0);
        P_IN = 48'h9;
        step();
        P_IN = 48'hDEAD;
        check("stall_out", 64'(OUT), 64'h9);
        check("stall_push_count", 64'(COUNT), 64'd1);
        step(); step(); step();
        P_IN = '0;
        check("stall_no_ghost", 64'(COUNT), 64'd1);
        OUT_READY = 1'b1;
        step();
        OUT_READY = 1'b0;
        check("stall_drained", 64'(COUNT), 64'd0);

        // Fill to full; credit drops once tokens + COUNT reach DEPTH
        IN_VALID = 1'b1;
        step(); step(); step();
        check("credit_3", 64'(CREDIT_OK), 64'd1);
        P_IN = 48'h1;
        step();
        IN_VALID = 1'b0;
        check("credit_4", 64'(CREDIT_OK), 64'd0);
        P_IN = 48'h2;
        step();
        P_IN = 48'h3; CARRY_IN = 1'b1;
        step();
        P_IN = 48'h4; CARRY_IN = 1'b0;
        step();
        P_IN = '0;
        check("full_count", 64'(COUNT), 64'd4);
        check("full_credit", 64'(CREDIT_OK), 64'd0);
        check("full_head", 64'(OUT), 64'h1);

        // Overflow: push while full, no pop
        IN_VALID = 1'b1;
        step();
        IN_VALID = 1'b0;
        step(); step();
        check("ovf_before", 64'(OVERFLOW), 64'd0);
        P_IN = 48'h55;
        step();
        P_IN = '0;
        check("ovf_flag", 64'(OVERFLOW), 64'd1);
        check("ovf_count", 64'(COUNT), 64'd4);
        check("ovf_head", 64'(OUT), 64'h1);

        // Full push + pop on the same edge
        IN_VALID = 1'b1;
        step();
        IN_VALID = 1'b0;
        step(); step();
        P_IN = 48'hAAAA; OUT_READY = 1'b1;
        step();
        P_IN = '0; OUT_READY = 1'b0;
        check("pp_count", 64'(COUNT), 64'd4);
        check("pp_ovf", 64'(OVERFLOW), 64'd1);
        check("pp_head", 64'(OUT), 64'h2);
        check("pp_carry2", 64'(OUT_CARRY), 64'd0);

        OUT_READY = 1'b1;
        step();
        check("drain_3", 64'(OUT), 64'h3);
        check("drain_3_carry", 64'(OUT_CARRY), 64'd1);
        step();
        check("drain_4", 64'(OUT), 64'h4);
        check("drain_4_carry", 64'(OUT_CARRY), 64'd0);
        step();
        check("drain_aaaa", 64'(OUT), 64'hAAAA);
        step();
        check("drain_empty_valid", 64'(OUT_VALID), 64'd0);
        check("drain_empty_out", 64'(OUT), 64'd0);
        step();
        check("ready_when_empty", 64'(COUNT), 64'd0);
        OUT_READY = 1'b0;

        // Reset with CEIN=0 while a result is stored and a token is in flight
        IN_VALID = 1'b1;
        step(); step();
        IN_VALID = 1'b0;
        step();
        P_IN = 48'h11;
        step();
        P_IN = '0;
        check("pre_rst_count", 64'(COUNT), 64'd1);
        RSTIN = 1'b1; CEIN = 1'b0;
        step();
        RSTIN = 1'b0;
        check("rst2_count", 64'(COUNT), 64'd0);
        check("rst2_valid", 64'(OUT_VALID), 64'd0);
        check("rst2_out", 64'(OUT), 64'd0);
        check("rst2_carry", 64'(OUT_CARRY), 64'd0);
        check("rst2_ovf", 64'(OVERFLOW), 64'd0);
        check("rst2_credit", 64'(CREDIT_OK), 64'd1);
        CEIN = 1'b1; P_IN = 48'hBEEF;
        step(); step(); step();
        check("rst2_no_old_push", 64'(COUNT), 64'd0);
        check("rst2_no_old_valid", 64'(OUT_VALID), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
